lut_layer_sequencer: RTL and testbench
======================================

# lut_layer_sequencer

Time-multiplexed evaluator for one layer of LUT neurons. The per-neuron truth tables live in a single shared, runtime-programmable distributed memory instead of one hard-coded ROM per neuron. The block accepts one pre-gathered fan-in vector, walks the neurons one per cycle through the shared table memory and assembles the layer's output word. It sits between two layer stages of the network pipeline, with valid/ready handshakes on both sides and a configuration write port for loading truth tables.

## Interface
- NEURONS, 16, neurons in the layer (≥2)
- FANIN, 8, input bits per neuron; each table holds 2^FANIN one-bit entries
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_data  in  NEURONS*FANIN  neuron i's fan-in is in_data[i*FANIN +: FANIN]
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  NEURONS  bit i = output of neuron i
- cfg_we  in  1  truth-table write strobe
- cfg_addr  in  $clog2(NEURONS)+FANIN  {neuron index, table entry}
- cfg_wdata  in  1  table bit to write
- cfg_ready  out  1  config writes are accepted
- cfg_err  out  1  one-cycle pulse: write arrived while cfg_ready low
- busy  out  1  state ≠ IDLE

## Operation
- Table memory: NEURONS*2^FANIN bits, synchronous write, registered read with 1-cycle latency. It is not reset.
- Lookup: neuron i's entry address is {i, in_data_reg[i*FANIN +: FANIN]}, with the slice read as unsigned.
- FSM states IDLE, RUN, DRAIN, OUT.
  - IDLE: in_ready=1 and cfg_ready=1. On in_valid, capture in_data into in_data_reg, clear cnt to 0 and go to RUN.
  - RUN: issue the read for neuron cnt. Capture the previous read's bit into out_data[cnt-1]. When cnt==NEURONS-1, go to DRAIN; otherwise increment cnt.
  - DRAIN: capture out_data[NEURONS-1] and go to OUT.
  - OUT: out_valid=1. Hold out_data stable until out_ready, then go to IDLE.
- in_ready is 0 in RUN, DRAIN and OUT, so no vector is accepted outside IDLE.
- Config writes:
  - cfg_we is honoured only when cfg_ready=1 (IDLE).
  - cfg_we in any other state is dropped and cfg_err pulses high for the following cycle.
- cfg_we and an in_valid accept in the same IDLE cycle: both take effect. The first read occurs the next cycle, so the new bit is visible to that vector.
- out_data bits not yet rewritten keep their previous values during RUN and DRAIN. out_data is meaningful only while out_valid=1.

## Timing
- Reset values (while rst_n=0 and immediately after):
  - state=IDLE, cnt=0
  - out_valid=0, out_data=0
  - in_ready=1, cfg_ready=1
  - cfg_err=0, busy=0
- Latency: the accept edge (IDLE→RUN) is edge E0. out_valid rises after edge E(NEURONS+1), which is 17 cycles for the default NEURONS=16.
- Minimum period with out_ready held high is NEURONS+3 cycles: RUN NEURONS, DRAIN 1, OUT 1, IDLE 1.
- Backpressure: OUT is held indefinitely. out_valid and out_data do not change until out_ready=1.
- Reset mid-operation: the vector in flight is discarded and out_valid is never asserted for it. Table contents are retained.
- in_ready, cfg_ready and busy are decoded from the state register (no combinational path from inputs).

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> out_valid=0, out_data=0, in_ready=1, cfg_ready=1, busy=0 immediately.
- Programming plus evaluation:
  - Stimulus: write entry {i, i}=1 for i=0..15 (all other entries 0). Send a vector with slice i = i.
  - Required response: out_data=16'hFFFF, out_valid exactly 17 cycles after accept.
  - Stimulus: resend with slice i = i+1.
  - Required response: out_data=16'h0000.
- Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid stays 1, out_data stable, in_ready=0. Raise out_ready -> IDLE next cycle, then a new vector is accepted.
- Config during RUN:
  - Stimulus: cfg_we with {5, 0x05}=0 at the 4th RUN cycle.
  - Required response: cfg_err=1 for one cycle. A rerun of the same vector still gives out_data[5]=1.
- Reset mid-RUN: assert rst_n=0 at the 6th RUN cycle -> no out_valid. After release, the next vector gives the correct result with tables unchanged.
- Simultaneous write and accept in IDLE: write {3, 0x00}=1 while accepting a vector with slice3=0x00 -> out_data[3]=1.

Source files
------------

// File: rtl/lut_layer_sequencer_if.sv
// Handshake, result and configuration signals of one LUT layer sequencer.
interface lut_layer_sequencer_if #(
    parameter int NEURONS = 16,
    parameter int FANIN   = 8
);
    localparam int CAW = $clog2(NEURONS) + FANIN;

    logic                       in_valid;
    logic                       in_ready;
    logic [NEURONS*FANIN-1:0]   in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [NEURONS-1:0]         out_data;
    logic                       cfg_we;
    logic [CAW-1:0]             cfg_addr;
    logic                       cfg_wdata;
    logic                       cfg_ready;
    logic                       cfg_err;
    logic                       busy;

    // Upstream / configuration side driving the sequencer
    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_data, cfg_ready, cfg_err, busy
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_data, cfg_ready, cfg_err, busy
    );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LUT-neuron layer: one shared truth-table memory, one
// neuron looked up per cycle, result word presented with valid/ready.
module lut_layer_sequencer #(
    parameter int NEURONS = 16,
    parameter int FANIN   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lut_layer_sequencer_if.slave bus
);
    localparam int CW    = $clog2(NEURONS);
    localparam int AW    = CW + FANIN;
    localparam int DEPTH = NEURONS * (2 ** FANIN);
    localparam logic [CW-1:0] LAST = CW'(NEURONS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [NEURONS*FANIN-1:0]  in_data_q;
    logic [NEURONS-1:0]        out_data_q;
    logic                      cfg_err_q;

    logic                      table_mem [DEPTH];
    logic                      rd_bit_q;
    logic [AW-1:0]             rd_addr;
    logic [CW-1:0]             prev_idx;
    logic                      accept;
    logic                      cfg_wr;

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign cfg_wr   = (state_q == IDLE) && bus.cfg_we;
    assign rd_addr  = {cnt_q, in_data_q[cnt_q*FANIN +: FANIN]};
    assign prev_idx = cnt_q - CW'(1);

    // State and neuron counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: walk neurons 0..NEURONS-1, one extra cycle to catch the last read
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == LAST) state_d = DRAIN;
                else               cnt_d   = cnt_q + CW'(1);
            end
            DRAIN:   state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded purely from the state register
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.cfg_ready = (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.out_valid = (state_q == OUT);
        bus.out_data  = out_data_q;
        bus.cfg_err   = cfg_err_q;
    end

    // Datapath: capture the vector, collect each read bit one cycle after its
    // address was issued, and flag configuration writes that arrive while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_data_q  <= '0;
            out_data_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_we && (state_q != IDLE);
            if (accept) in_data_q <= bus.in_data;
            if (state_q == RUN && cnt_q != '0) out_data_q[prev_idx] <= rd_bit_q;
            if (state_q == DRAIN) out_data_q[NEURONS-1] <= rd_bit_q;
        end
    end

    // Truth-table memory: no reset so contents survive rst_n; registered read
    always_ff @(posedge clk) begin
        if (cfg_wr) table_mem[bus.cfg_addr] <= bus.cfg_wdata;
        rd_bit_q <= table_mem[rd_addr];
    end
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Bench for lut_layer_sequencer: programs the tables, runs a vector table
// through a scoreboard, then exercises backpressure, busy writes and reset.
module tb_lut_layer_sequencer;
    localparam int N = 16;
    localparam int F = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bit           tbl [N][256];
    logic [15:0]  sb [$];

    lut_layer_sequencer_if #(.NEURONS(N), .FANIN(F)) bus ();

    lut_layer_sequencer #(.NEURONS(N), .FANIN(F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] data;
        logic [15:0]  exp;
        int           hold;
    } vec_t;

    vec_t vecs [6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int mode);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       v[i*F +: F] = 8'(i);
                1:       v[i*F +: F] = 8'(i + 1);
                2:       v[i*F +: F] = 8'h00;
                3:       v[i*F +: F] = 8'hFF;
                4:       v[i*F +: F] = (i % 2 == 0) ? 8'(i) : 8'h00;
                default: v[i*F +: F] = 8'(i) ^ 8'h10;
            endcase
        end
        return v;
    endfunction

    function automatic logic [15:0] model_eval(input logic [127:0] d);
        logic [15:0] r;
        for (int i = 0; i < N; i++) r[i] = tbl[i][d[i*F +: F]];
        return r;
    endfunction

    // One vector through the block; optionally a config write at RUN cycle inj_at
    task automatic run_vec(input string nm, input logic [127:0] d, input logic [15:0] exp,
                           input int hold, input int inj_at);
        int          n;
        int          lat;
        bit          err_pending;
        logic [15:0] got;
        logic [15:0] e;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk({nm, " in_ready before accept"}, 128'(bus.in_ready), 128'(1));
        tick();
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        sb.push_back(exp);
        chk({nm, " busy in RUN"}, 128'(bus.busy), 128'(1));
        chk({nm, " cfg_ready in RUN"}, 128'(bus.cfg_ready), 128'(0));
        lat = 0;
        err_pending = 1'b0;
        while (!bus.out_valid && lat < 60) begin
            if (lat == inj_at) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = {4'd5, 8'h05};
                bus.cfg_wdata = 1'b0;
            end
            tick();
            lat++;
            if (bus.cfg_we) begin
                bus.cfg_we = 1'b0;
                chk({nm, " cfg_err pulse"}, 128'(bus.cfg_err), 128'(1));
                err_pending = 1'b1;
            end else if (err_pending) begin
                chk({nm, " cfg_err one cycle"}, 128'(bus.cfg_err), 128'(0));
                err_pending = 1'b0;
            end
        end
        chk({nm, " out_valid seen"}, 128'(bus.out_valid), 128'(1));
        chk({nm, " latency"}, 128'(lat), 128'(N + 1));
        got = bus.out_data;
        if (sb.size() == 0) begin
            chk({nm, " scoreboard entry present"}, 128'(0), 128'(1));
        end else begin
            e = sb.pop_front();
            chk({nm, " out_data"}, 128'(got), 128'(e));
        end
        $display("vec %s: out_data=%h exp=%h latency=%0d", nm, got, exp, lat);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({nm, " hold out_valid"}, 128'(bus.out_valid), 128'(1));
            chk({nm, " hold out_data"}, 128'(bus.out_data), 128'(got));
            chk({nm, " hold in_ready"}, 128'(bus.in_ready), 128'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({nm, " back to IDLE out_valid"}, 128'(bus.out_valid), 128'(0));
        chk({nm, " back to IDLE in_ready"}, 128'(bus.in_ready), 128'(1));
    endtask

    initial begin
        bit seen;
        logic [15:0] got;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = 1'b0;

        vecs[0] = '{"diag",      mk(0), 16'hFFFF, 10};
        vecs[1] = '{"diag+1",    mk(1), 16'h0000, 0};
        vecs[2] = '{"zeros",     mk(2), 16'h0001, 0};
        vecs[3] = '{"ones",      mk(3), 16'h0000, 0};
        vecs[4] = '{"even_diag", mk(4), 16'h5555, 0};
        vecs[5] = '{"xor10",     mk(5), 16'h0000, 0};

        // Asynchronous reset in the middle of a cycle
        #3 rst_n = 1'b0;
        #1;
        chk("reset out_valid", 128'(bus.out_valid), 128'(0));
        chk("reset out_data", 128'(bus.out_data), 128'(0));
        chk("reset in_ready", 128'(bus.in_ready), 128'(1));
        chk("reset cfg_ready", 128'(bus.cfg_ready), 128'(1));
        chk("reset busy", 128'(bus.busy), 128'(0));
        chk("reset cfg_err", 128'(bus.cfg_err), 128'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Program every entry: {i,i}=1, everything else 0
        for (int n = 0; n < N; n++) begin
            for (int e = 0; e < 256; e++) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = {4'(n), 8'(e)};
                bus.cfg_wdata = (n == e);
                tbl[n][e]     = (n == e);
                tick();
            end
        end
        bus.cfg_we = 1'b0;
        chk("no cfg_err while programming in IDLE", 128'(bus.cfg_err), 128'(0));

        for (int v = 0; v < 6; v++)
            run_vec(vecs[v].name, vecs[v].data, vecs[v].exp, vecs[v].hold, -1);

        // Write during RUN is dropped; the stored bit stays 1
        run_vec("cfg_in_run", mk(0), model_eval(mk(0)), 0, 3);
        bus.in_data  = mk(0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = bus.out_valid;
        end
        got = bus.out_data;
        chk("rerun out_valid", 128'(seen), 128'(1));
        chk("rerun out_data[5]", 128'(got[5]), 128'(1));
        $display("vec rerun: out_data=%h", got);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset at the 6th RUN cycle discards the vector
        bus.in_data  = mk(0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        sb.push_back(16'hFFFF);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrun reset busy", 128'(bus.busy), 128'(0));
        chk("midrun reset in_ready", 128'(bus.in_ready), 128'(1));
        chk("midrun reset out_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        void'(sb.pop_back());
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("no out_valid after midrun reset", 128'(seen), 128'(0));
        $display("vec midrun_reset: discarded");
        run_vec("after_reset", mk(0), 16'hFFFF, 0, -1);

        // Write and accept in the same IDLE cycle
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = {4'd3, 8'h00};
        bus.cfg_wdata = 1'b1;
        tbl[3][0]     = 1'b1;
        run_vec("write_and_accept", mk(2), 16'h0009, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
